// File: rtl/rpn_stack_if.sv
// rpn_stack_if: command and status bundle of the RPN operand stack.
//   master : drives sw_val, push_p, pop_p, op_p, op_sel (button chain / switches)
//            and observes top, non_empty, depth, busy, err, ovf (displays).
//   slave  : the stack engine itself.
interface rpn_stack_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic signed [W-1:0]  sw_val;
  logic                 push_p;
  logic                 pop_p;
  logic                 op_p;
  logic [1:0]           op_sel;
  logic signed [W-1:0]  top;
  logic                 non_empty;
  logic [DW-1:0]        depth;
  logic                 busy;
  logic                 err;
  logic                 ovf;

  modport master (
    output sw_val, push_p, pop_p, op_p, op_sel,
    input  top, non_empty, depth, busy, err, ovf
  );

  modport slave (
    input  sw_val, push_p, pop_p, op_p, op_sel,
    output top, non_empty, depth, busy, err, ovf
  );
endinterface

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: signed operand stack and arithmetic core of the RPN
// calculator. Executes push / pop / add / sub / swap in one cycle and a
// W-iteration shift-add signed multiply.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rpn_stack_if.slave
//            in  sw_val, push_p, pop_p, op_p, op_sel
//            out top, non_empty, depth, busy, err, ovf (all register-decoded)
module rpn_stack_engine #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  rpn_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  // Magnitude needs W+1 bits so that |-2^(W-1)| is representable.
  function automatic logic [W:0] mag(input logic signed [W-1:0] v);
    logic signed [W:0] e;
    e = {v[W-1], v};
    return v[W-1] ? -e : e;
  endfunction

  function automatic logic fits_w1(input logic signed [W:0] v);
    return v[W] == v[W-1];
  endfunction

  function automatic logic fits_2w(input logic signed [2*W-1:0] v);
    return (&v[2*W-1:W-1]) | ~(|v[2*W-1:W-1]);
  endfunction

  // Control state
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] depth_q;
  logic          err_q;
  logic          ovf_q;

  // Data state: stk[0] is T, stk[1] is N; not reset, masked by depth_q.
  logic signed [W-1:0] stk [DEPTH];
  logic [2*W-1:0]      acc;
  logic [2*W-1:0]      mcand;
  logic [W:0]          mplier;
  logic                neg;

  logic signed [W:0]     add_w;
  logic signed [W:0]     sub_w;
  logic [2*W-1:0]        acc_nxt;
  logic signed [2*W-1:0] prod;
  logic                  do_push, do_pop, do_bin, do_swap, mul_start;
  logic signed [W-1:0]   res;

  assign add_w   = $signed({stk[1][W-1], stk[1]}) + $signed({stk[0][W-1], stk[0]});
  assign sub_w   = $signed({stk[1][W-1], stk[1]}) - $signed({stk[0][W-1], stk[0]});
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign prod    = neg ? -$signed(acc_nxt) : $signed(acc_nxt);

  // Command decode: one accepted command per cycle, push > pop > op.
  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_bin    = 1'b0;
    do_swap   = 1'b0;
    mul_start = 1'b0;
    res       = '0;
    if (state == S_IDLE) begin
      if (bus.push_p) begin
        do_push = (depth_q != DW'(DEPTH));
      end else if (bus.pop_p) begin
        do_pop = (depth_q != '0);
      end else if (bus.op_p && depth_q >= DW'(2)) begin
        case (bus.op_sel)
          2'b00:   begin do_bin = 1'b1; res = add_w[W-1:0]; end
          2'b01:   begin do_bin = 1'b1; res = sub_w[W-1:0]; end
          2'b10:   mul_start = 1'b1;
          default: do_swap = 1'b1;
        endcase
      end
    end else if (cnt == CW'(W - 1)) begin
      do_bin = 1'b1;
      res    = prod[W-1:0];
    end
  end

  // Stack and multiplier datapath
  always_ff @(posedge clk) begin
    if (do_push) begin
      stk[0] <= bus.sw_val;
      for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
    end else if (do_bin) begin
      stk[0] <= res;
      for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
    end else if (do_swap) begin
      stk[0] <= stk[1];
      stk[1] <= stk[0];
    end

    if (mul_start) begin
      acc    <= '0;
      mcand  <= {{(W-1){1'b0}}, mag(stk[1])};
      mplier <= mag(stk[0]);
      neg    <= stk[1][W-1] ^ stk[0][W-1];
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Control: FSM, depth and level flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.push_p) begin
            err_q <= ~do_push;
            ovf_q <= 1'b0;
            if (do_push) depth_q <= depth_q + DW'(1);
          end else if (bus.pop_p) begin
            err_q <= ~do_pop;
            ovf_q <= 1'b0;
            if (do_pop) depth_q <= depth_q - DW'(1);
          end else if (bus.op_p) begin
            if (depth_q < DW'(2)) begin
              err_q <= 1'b1;
            end else begin
              case (bus.op_sel)
                2'b00: begin
                  err_q   <= 1'b0;
                  ovf_q   <= ~fits_w1(add_w);
                  depth_q <= depth_q - DW'(1);
                end
                2'b01: begin
                  err_q   <= 1'b0;
                  ovf_q   <= ~fits_w1(sub_w);
                  depth_q <= depth_q - DW'(1);
                end
                2'b10: begin
                  state <= S_MUL;
                  cnt   <= '0;
                end
                default: begin
                  err_q <= 1'b0;
                  ovf_q <= 1'b0;
                end
              endcase
            end
          end
        end
        default: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state   <= S_IDLE;
            depth_q <= depth_q - DW'(1);
            err_q   <= 1'b0;
            ovf_q   <= ~fits_2w(prod);
          end
        end
      endcase
    end
  end

  assign bus.top       = (depth_q != '0) ? stk[0] : '0;
  assign bus.non_empty = (depth_q != '0);
  assign bus.depth     = depth_q;
  assign bus.busy      = (state == S_MUL);
  assign bus.err       = err_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/rpn_stack_engine.md
# rpn_stack_engine

Operand stack and arithmetic core of the RPN calculator. It consumes single-cycle command pulses, produced by the Debounce/Synchroniser/DetectFallingEdge button chain, and an 8-bit switch value. It maintains a signed operand stack and executes push, pop, add, subtract, multiply and swap. The top-of-stack value and the non-empty flag drive the decimal display (Disp2cNum `x` / `enable`); the top value also drives the hex display.

## Interface
- `W`, 8: operand width, two's complement.
- `DEPTH`, 4: stack entries (≥2).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sw_val`  in  W  value pushed on `push_p`, interpreted as signed.
- `push_p`  in  1  one-cycle command pulse: push `sw_val`.
- `pop_p`  in  1  one-cycle command pulse: discard top.
- `op_p`  in  1  one-cycle command pulse: execute `op_sel`.
- `op_sel`  in  2  operation: 00 add, 01 sub, 10 mul, 11 swap; sampled with `op_p`.
- `top`  out  W  signed top-of-stack value; 0 when empty.
- `non_empty`  out  1  depth > 0.
- `depth`  out  clog2(DEPTH+1)  current entry count.
- `busy`  out  1  multiply in progress.
- `err`  out  1  last command was rejected (stack fault).
- `ovf`  out  1  last arithmetic result did not fit in W bits.

## Operation
- Reset: stack cleared, depth 0, `top` 0, `non_empty`/`busy`/`err`/`ovf` all 0, FSM in IDLE.
- Notation: T = top entry, N = entry below it.
- FSM states: IDLE and MUL.
- IDLE accepts at most one command per cycle, with priority push > pop > op. Lower-priority simultaneous pulses are dropped silently.
- push: if depth < DEPTH, `sw_val` becomes T, depth+1, `err` 0. If full, stack unchanged, `err` 1.
- pop: if depth ≥ 1, depth−1, `err` 0. If empty, `err` 1.
- op with depth < 2: stack unchanged, `err` 1, `ovf` unchanged.
- add / sub: result N+T or N−T, truncated to W bits. It replaces both entries, depth−1, `err` 0. `ovf` is 1 iff the exact result lies outside [−2^(W−1), 2^(W−1)−1].
- swap: T and N exchanged, depth unchanged, `err` 0, `ovf` 0.
- mul: capture |N|, |T| and the sign (sign N xor sign T), then enter MUL.
  - W iterations of shift-add build a 2W-bit unsigned product.
  - Negate the product if the sign is 1.
  - Write the low W bits as the new T, depth−1, `err` 0.
  - `ovf` is 1 iff the signed 2W-bit product is outside the W-bit range.
  - |−128| is handled as 128 using a W+1-bit magnitude.
- In MUL, all pulses are ignored: no stack change, no flag change.
- `push`, `pop` and `swap` clear `ovf`.
- Reset asserted mid-multiply aborts the operation and returns to the reset state.

## Timing
- Single-cycle commands: pulse sampled at edge k; `top`, `depth` and flags reflect the result after edge k (visible in cycle k+1).
- mul accepted at edge k: `busy` is 1 from cycle k+1 through cycle k+W. The result is written at edge k+W, and `busy` is 0 in cycle k+W+1 together with the new `top`.
- A command pulse in the first cycle with `busy` = 0 after a multiply is accepted.
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.
- `err` and `ovf` are level flags held until the next accepted command.

## Test plan
- Reset, then push 5, push −3, add: `top` = 2, depth 1, `ovf` 0, `err` 0; `non_empty` 1 throughout.
- Push 100, push 50, add: `top` = −106, `ovf` 1. Then push 7: `ovf` 0, `top` = 7.
- Push −12, push 11, mul (op_sel 10): `busy` high for exactly 8 cycles, then `top` = −132 mod 256 = 124, `ovf` 1. Repeat with −4 × 6: `top` = −24, `ovf` 0. Repeat with −128 × −1: `top` = −128, `ovf` 1.
- Push 4 values, then a 5th push: `err` 1, depth 4, `top` unchanged. Pop ×4, then pop again: `err` 1, depth 0, `top` 0, `non_empty` 0.
- Op with depth 1: `err` 1, stack unchanged. `push_p` and `op_p` in the same cycle: only the push takes effect. Pulses during `busy`: ignored.
- Push 9, push 2, sub: `top` = 7. Then swap with depth 1: `err` 1. Assert `rst_n` low mid-mul: all outputs 0 immediately, and `busy` stays 0 after release.
